// File: rtl/aemb_pkg.sv
// ----------------------------------------------------------------------------
// aemb_pkg
// Shared definitions for the AEMB writeback stage:
//   - opcode constants (default multiply opcode, load-class mask/match)
//   - load size encodings SZ_BYTE / SZ_HALF / SZ_WORD
//   - result-select enum (ALU / MUL / LD)
//   - writeback FSM state enum
//   - pipeline stage record carried X->M->W
// ----------------------------------------------------------------------------
package aemb_pkg;

    // Default opcode of a multiply instruction.
    localparam logic [5:0] MULOP_DFLT = 6'h10;

    // Load class: opc[5:4]==2'b11 and opc[2]==0.
    localparam logic [5:0] LD_MASK  = 6'b110100;
    localparam logic [5:0] LD_MATCH = 6'b110000;

    // Load size encodings (2'b11 is treated as a word).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_MUL = 2'b01,
        SEL_LD  = 2'b10
    } sel_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LDWAIT = 1'b1
    } state_e;

    // Everything the writeback needs to know about one instruction.
    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        wren;
        sel_e        sel;
        logic [1:0]  siz;
        logic [1:0]  ofs;
    } stage_t;

    function automatic logic is_load(input logic [5:0] opc);
        return (opc & LD_MASK) == LD_MATCH;
    endfunction

endpackage

// File: rtl/aemb_ldalign.sv
// ----------------------------------------------------------------------------
// aemb_ldalign
// Combinational big-endian load alignment with zero extension.
// Ports:
//   dat     in  32  raw data-bus word
//   siz     in  2   load size (byte / half / word; 2'b11 acts as word)
//   ofs     in  2   byte address bits [1:0]
//   aligned out 32  right-justified, zero-extended load value
// ----------------------------------------------------------------------------
module aemb_ldalign
    import aemb_pkg::*;
(
    input  logic [31:0] dat,
    input  logic [1:0]  siz,
    input  logic [1:0]  ofs,
    output logic [31:0] aligned
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for the bits a branch leaves untouched.
        aligned = '0;
        case (siz)
            SZ_BYTE: begin
                // Byte 0 is the most significant lane (big-endian bus).
                case (ofs)
                    2'd0: aligned[7:0] = dat[31:24];
                    2'd1: aligned[7:0] = dat[23:16];
                    2'd2: aligned[7:0] = dat[15:8];
                    2'd3: aligned[7:0] = dat[7:0];
                endcase
            end
            SZ_HALF: aligned[15:0] = ofs[1] ? dat[15:0] : dat[31:16];
            default: aligned = dat;
        endcase
    end

endmodule

// File: rtl/aemb_wback.sv
// ----------------------------------------------------------------------------
// aemb_wback
// Writeback stage following the 2-stage multiplier. Carries destination and
// result-select through M and W (aligned with multiplier latency), picks ALU,
// multiplier or aligned load data at W, and stalls while a load waits for its
// data-bus ack.
// Configuration macro: AEMB_MUL_EN
//   defined   -> multiply results drive m_mul onto w_dat
//   undefined -> multiply instructions write 32'h0; m_mul is unused
// Ports:
//   gclk       in   1   clock, rising edge
//   grst       in   1   synchronous reset, active-high
//   gena       in   1   pipeline enable
//   x_alu      in   32  ALU result of the instruction in X
//   x_opc      in   6   opcode of the instruction in X
//   x_rd       in   5   destination register
//   x_wren     in   1   instruction writes a register
//   x_siz      in   2   load size
//   x_ofs      in   2   load address bits [1:0]
//   m_mul      in   32  multiplier result for the instruction in W
//   dwb_dat_i  in   32  data-bus read data
//   dwb_ack_i  in   1   data-bus ack
//   w_rd       out  5   register-file write address
//   w_dat      out  32  register-file write data
//   w_we       out  1   register-file write enable
//   w_stall    out  1   load data outstanding
// ----------------------------------------------------------------------------
module aemb_wback
    import aemb_pkg::*;
#(
    parameter int         DW    = 32,
    parameter logic [5:0] MULOP = MULOP_DFLT
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          gena,
    input  logic [DW-1:0] x_alu,
    input  logic [5:0]    x_opc,
    input  logic [4:0]    x_rd,
    input  logic          x_wren,
    input  logic [1:0]    x_siz,
    input  logic [1:0]    x_ofs,
    input  logic [DW-1:0] m_mul,
    input  logic [DW-1:0] dwb_dat_i,
    input  logic          dwb_ack_i,
    output logic [4:0]    w_rd,
    output logic [DW-1:0] w_dat,
    output logic          w_we,
    output logic          w_stall
);

    logic    x_is_ld;
    sel_e    x_sel;
    stage_t  x_stage;
    stage_t  m_stage;
    stage_t  w_stage;
    state_e  state;
    logic [DW-1:0] ld_dat;
    logic [DW-1:0] ld_aligned;

    // ---------------- X classification ----------------
    assign x_is_ld = is_load(x_opc);
    assign x_sel   = x_is_ld            ? SEL_LD  :
                     (x_opc == MULOP)   ? SEL_MUL : SEL_ALU;

    assign x_stage = '{alu: x_alu, rd: x_rd, wren: x_wren, sel: x_sel,
                       siz: x_siz, ofs: x_ofs};

    // ---------------- X->M->W pipeline ----------------
    always_ff @(posedge gclk) begin
        // NOTE: sequential state uses non-blocking assignments so W picks up
        // the old M value on the same edge that M takes the new X value.
        if (grst) begin
            m_stage <= '0;
            w_stage <= '0;
        end else if (gena) begin
            m_stage <= x_stage;
            w_stage <= m_stage;
        end
    end

    // ---------------- Load handshake FSM ----------------
    // The load sits in M while waiting; its data is captured here and used
    // once the load reaches W. The ack in LDWAIT is taken regardless of gena
    // because the core holds gena low for the whole stall.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state  <= ST_IDLE;
            ld_dat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gena && x_is_ld) begin
                        if (dwb_ack_i) ld_dat <= dwb_dat_i;
                        else           state  <= ST_LDWAIT;
                    end
                end
                ST_LDWAIT: begin
                    if (dwb_ack_i) begin
                        ld_dat <= dwb_dat_i;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign w_stall = (state == ST_LDWAIT);

    // ---------------- W result select ----------------
    aemb_ldalign u_ldalign (
        .dat     (ld_dat),
        .siz     (w_stage.siz),
        .ofs     (w_stage.ofs),
        .aligned (ld_aligned)
    );

`ifndef AEMB_MUL_EN
    logic unused_mul;
    assign unused_mul = ^m_mul;
`endif

    always_comb begin
        w_dat = w_stage.alu;
        case (w_stage.sel)
            SEL_MUL: begin
`ifdef AEMB_MUL_EN
                w_dat = m_mul;
`else
                w_dat = '0;
`endif
            end
            SEL_LD:  w_dat = ld_aligned;
            default: w_dat = w_stage.alu;
        endcase
    end

    assign w_rd = w_stage.rd;
    // r0 is hardwired to zero and is never written.
    assign w_we = w_stage.wren & (w_stage.rd != 5'd0);

endmodule

// File: tb/tb_aemb_wback.sv
// ----------------------------------------------------------------------------
// tb_aemb_wback
// Self-checking bench for aemb_wback: a streamed vector table with a
// scoreboard queue, plus hand-written sequences for stalled loads, idle acks,
// reset during a pending load and a non-writing load.
// ----------------------------------------------------------------------------
module tb_aemb_wback;

    localparam logic [5:0] MULOP = 6'h10;
    localparam int NV = 18;

    logic        gclk = 1'b0;
    logic        grst;
    logic        gena;
    logic [31:0] x_alu;
    logic [5:0]  x_opc;
    logic [4:0]  x_rd;
    logic        x_wren;
    logic [1:0]  x_siz;
    logic [1:0]  x_ofs;
    logic [31:0] m_mul;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i;
    logic [4:0]  w_rd;
    logic [31:0] w_dat;
    logic        w_we;
    logic        w_stall;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] alu;
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic        wren;
        logic [1:0]  siz;
        logic [1:0]  ofs;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] bus;
        logic        exp_we;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] dat;
        logic [31:0] mul;
    } exp_t;

    vec_t vec [NV];
    exp_t sb [$];

    aemb_wback #(.DW(32), .MULOP(MULOP)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .gena      (gena),
        .x_alu     (x_alu),
        .x_opc     (x_opc),
        .x_rd      (x_rd),
        .x_wren    (x_wren),
        .x_siz     (x_siz),
        .x_ofs     (x_ofs),
        .m_mul     (m_mul),
        .dwb_dat_i (dwb_dat_i),
        .dwb_ack_i (dwb_ack_i),
        .w_rd      (w_rd),
        .w_dat     (w_dat),
        .w_we      (w_we),
        .w_stall   (w_stall)
    );

    always #5 gclk = ~gclk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_x(input logic [31:0] alu, input logic [5:0] opc,
                           input logic [4:0] rd, input logic wren,
                           input logic [1:0] siz, input logic [1:0] ofs);
        x_alu  = alu;
        x_opc  = opc;
        x_rd   = rd;
        x_wren = wren;
        x_siz  = siz;
        x_ofs  = ofs;
    endtask

    task automatic bubble();
        drive_x(32'h0, 6'h00, 5'd0, 1'b0, 2'd0, 2'd0);
    endtask

    // Hard stop in case anything ever wedges the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0] vpipe;
        logic       issued;
        exp_t       e;

        //              alu           opc    rd     wr    siz   ofs   ma      mb      bus           we    exp
        vec[0]  = '{32'hDEADBEEF, 6'h00, 5'd3,  1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b1, 32'hDEADBEEF};
        vec[1]  = '{32'h12345678, 6'h00, 5'd0,  1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b0, 32'h12345678};
        vec[2]  = '{32'h0BADF00D, 6'h10, 5'd5,  1'b1, 2'd0, 2'd0, 32'd7, 32'd6, 32'h0,        1'b1, 32'd42};
        vec[3]  = '{32'hA5A5A5A5, 6'h11, 5'd31, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b1, 32'hA5A5A5A5};
        vec[4]  = '{32'h13579BDF, 6'h30, 5'd7,  1'b1, 2'd1, 2'd3, 32'd0, 32'd0, 32'hAABBCCDD, 1'b1, 32'h0000CCDD};
        vec[5]  = '{32'hCAFEF00D, 6'h34, 5'd8,  1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b1, 32'hCAFEF00D};
        vec[6]  = '{32'h00000000, 6'h31, 5'd9,  1'b1, 2'd0, 2'd1, 32'd0, 32'd0, 32'h11223344, 1'b1, 32'h00000022};
        vec[7]  = '{32'h22222222, 6'h10, 5'd10, 1'b0, 2'd0, 2'd0, 32'd3, 32'd5, 32'h0,        1'b0, 32'd15};
        vec[8]  = '{32'h00000000, 6'h3B, 5'd11, 1'b1, 2'd2, 2'd1, 32'd0, 32'd0, 32'h89ABCDEF, 1'b1, 32'h89ABCDEF};
        vec[9]  = '{32'h0F0F0F0F, 6'h20, 5'd12, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b1, 32'h0F0F0F0F};
        vec[10] = '{32'h00000000, 6'h38, 5'd13, 1'b1, 2'd3, 2'd2, 32'd0, 32'd0, 32'h01020304, 1'b1, 32'h01020304};
        vec[11] = '{32'h00000001, 6'h3F, 5'd14, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b1, 32'h00000001};
        vec[12] = '{32'h00000000, 6'h32, 5'd15, 1'b1, 2'd0, 2'd3, 32'd0, 32'd0, 32'hA1B2C3D4, 1'b1, 32'h000000D4};
        vec[13] = '{32'h44444444, 6'h10, 5'd16, 1'b1, 2'd0, 2'd0, 32'h1234, 32'h10, 32'h0,    1'b1, 32'h00012340};
        vec[14] = '{32'h80000000, 6'h0F, 5'd18, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b1, 32'h80000000};
        vec[15] = '{32'h00000000, 6'h30, 5'd2,  1'b1, 2'd1, 2'd0, 32'd0, 32'd0, 32'hAABBCCDD, 1'b1, 32'h0000AABB};
        vec[16] = '{32'h00000007, 6'h05, 5'd19, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h0,        1'b1, 32'h00000007};
        vec[17] = '{32'h00000000, 6'h30, 5'd20, 1'b1, 2'd0, 2'd0, 32'd0, 32'd0, 32'h11223344, 1'b1, 32'h00000011};

        // ---------------- Reset with busy inputs ----------------
        grst      = 1'b1;
        gena      = 1'b1;
        drive_x(32'hFFFFFFFF, 6'h30, 5'd7, 1'b1, 2'd2, 2'd0);
        m_mul     = 32'h0000FFFF;
        dwb_dat_i = 32'h12345678;
        dwb_ack_i = 1'b1;
        repeat (2) @(negedge gclk);
        check("reset_w_we",    {31'd0, w_we},    32'd0);
        check("reset_w_dat",   w_dat,            32'd0);
        check("reset_w_rd",    {27'd0, w_rd},    32'd0);
        check("reset_w_stall", {31'd0, w_stall}, 32'd0);

        grst      = 1'b0;
        dwb_ack_i = 1'b0;
        dwb_dat_i = 32'h0;
        m_mul     = 32'h0;
        bubble();

        // ---------------- Streamed vectors with scoreboard ----------------
        vpipe  = 2'b00;
        issued = 1'b0;
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge gclk);
            vpipe = {vpipe[0], issued};
            if (vpipe[1]) begin
                e     = sb.pop_front();
                m_mul = e.mul;
                #1;
                check("stream_w_rd",  {27'd0, w_rd}, {27'd0, e.rd});
                check("stream_w_we",  {31'd0, w_we}, {31'd0, e.we});
                check("stream_w_dat", w_dat,         e.dat);
            end else begin
                m_mul = 32'h0;
                #1;
            end
            check("stream_w_stall", {31'd0, w_stall}, 32'd0);

            if (i < NV) begin
                drive_x(vec[i].alu, vec[i].opc, vec[i].rd, vec[i].wren,
                        vec[i].siz, vec[i].ofs);
                // Loads in the table get their ack on the entry edge.
                dwb_ack_i = ((vec[i].opc[5:4] == 2'b11) && !vec[i].opc[2]);
                dwb_dat_i = vec[i].bus;
                e.rd  = vec[i].rd;
                e.we  = vec[i].exp_we;
                e.mul = vec[i].ma * vec[i].mb;
`ifdef AEMB_MUL_EN
                e.dat = vec[i].exp_dat;
`else
                e.dat = (vec[i].opc == MULOP) ? 32'h0 : vec[i].exp_dat;
`endif
                sb.push_back(e);
                issued = 1'b1;
            end else begin
                bubble();
                dwb_ack_i = 1'b0;
                issued    = 1'b0;
            end
        end
        check("scoreboard_empty", sb.size(), 32'd0);

        // ---------------- Byte load, ack three cycles late ----------------
        @(negedge gclk);
        m_mul = 32'h0;
        drive_x(32'h99999999, 6'h30, 5'd4, 1'b1, 2'd0, 2'd2);
        dwb_ack_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge gclk);
            check("late_ack_stall", {31'd0, w_stall}, 32'd1);
            gena = 1'b0;
            bubble();
            if (k == 3) begin
                dwb_ack_i = 1'b1;
                dwb_dat_i = 32'h11223344;
            end
        end
        @(negedge gclk);
        check("late_ack_stall_cleared", {31'd0, w_stall}, 32'd0);
        dwb_ack_i = 1'b0;
        dwb_dat_i = 32'h0;
        gena      = 1'b1;
        @(negedge gclk);
        check("late_ack_w_dat", w_dat,         32'h00000033);
        check("late_ack_w_rd",  {27'd0, w_rd}, 32'd4);
        check("late_ack_w_we",  {31'd0, w_we}, 32'd1);

        // ---------------- Idle ack and frozen pipeline ----------------
        gena = 1'b0;
        drive_x(32'h0, 6'h30, 5'd20, 1'b1, 2'd2, 2'd0);
        dwb_ack_i = 1'b1;
        dwb_dat_i = 32'hFFFFFFFF;
        @(negedge gclk);
        check("idle_ack_w_dat", w_dat,            32'h00000033);
        check("idle_ack_w_rd",  {27'd0, w_rd},    32'd4);
        check("idle_ack_stall", {31'd0, w_stall}, 32'd0);
        dwb_ack_i = 1'b0;
        @(negedge gclk);
        check("gena_low_load_no_stall", {31'd0, w_stall}, 32'd0);

        // ---------------- Reset during LDWAIT, then stray ack ----------------
        gena = 1'b1;
        drive_x(32'h0, 6'h33, 5'd6, 1'b1, 2'd1, 2'd0);
        @(negedge gclk);
        check("rst_ldwait_stall", {31'd0, w_stall}, 32'd1);
        gena = 1'b0;
        bubble();
        grst = 1'b1;
        @(negedge gclk);
        check("rst_ldwait_stall_clr", {31'd0, w_stall}, 32'd0);
        check("rst_ldwait_w_we",      {31'd0, w_we},    32'd0);
        check("rst_ldwait_w_dat",     w_dat,            32'd0);
        check("rst_ldwait_w_rd",      {27'd0, w_rd},    32'd0);
        grst      = 1'b0;
        dwb_ack_i = 1'b1;
        dwb_dat_i = 32'h77777777;
        @(negedge gclk);
        check("stray_ack_stall", {31'd0, w_stall}, 32'd0);
        check("stray_ack_w_dat", w_dat,            32'd0);
        dwb_ack_i = 1'b0;

        // ---------------- Non-writing load still handshakes ----------------
        gena = 1'b1;
        drive_x(32'h0, 6'h30, 5'd9, 1'b0, 2'd2, 2'd0);
        @(negedge gclk);
        check("nowr_load_stall", {31'd0, w_stall}, 32'd1);
        gena = 1'b0;
        bubble();
        dwb_ack_i = 1'b1;
        dwb_dat_i = 32'hCAFEBABE;
        @(negedge gclk);
        check("nowr_load_stall_clr", {31'd0, w_stall}, 32'd0);
        dwb_ack_i = 1'b0;
        dwb_dat_i = 32'h0;
        gena      = 1'b1;
        @(negedge gclk);
        check("nowr_load_w_we",  {31'd0, w_we},  32'd0);
        check("nowr_load_w_rd",  {27'd0, w_rd},  32'd9);
        check("nowr_load_w_dat", w_dat,          32'hCAFEBABE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
